fp_align: RTL

FP_ALIGN -- requirements
Module: fp_align

---
 rtl/fp_align.sv | 119 +++++++++++
 1 files changed

// File: rtl/fp_align.sv
// Exponent-compare and mantissa-alignment stage of a single-precision adder.
// Orders the operands by magnitude and right-shifts the smaller mantissa a few bits per clock, keeping guard/round/sticky.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | smaller mantissa being shifted right toward the larger exponent
// DONE  | aligned result presented, waiting for out_ready
module fp_align #(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        signA,
  input  logic        signB,
  input  logic [7:0]  exponentA,
  input  logic [7:0]  exponentB,
  input  logic [22:0] mantissaA,
  input  logic [22:0] mantissaB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        signL,
  output logic        signS,
  output logic [7:0]  exponentOut,
  output logic [23:0] mantL,
  output logic [26:0] mantS,
  output logic        swapped,
  output logic        special
);

  localparam logic [4:0] MAX_SHIFT = 5'd27;
  localparam logic [4:0] STEP      = 5'(SHIFT_PER_CYCLE);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [4:0] remaining;

  logic       hid_a, hid_b;
  logic [7:0] eff_a, eff_b;
  logic       a_larger;
  logic [7:0] exp_diff;
  logic [4:0] shift_init;
  logic       is_special;

  // Denormals use exponent 1 so they line up with the smallest normals.
  assign hid_a      = |exponentA;
  assign hid_b      = |exponentB;
  assign eff_a      = hid_a ? exponentA : 8'd1;
  assign eff_b      = hid_b ? exponentB : 8'd1;
  assign a_larger   = {eff_a, hid_a, mantissaA} >= {eff_b, hid_b, mantissaB};
  assign exp_diff   = a_larger ? (eff_a - eff_b) : (eff_b - eff_a);
  assign shift_init = (exp_diff > 8'd27) ? MAX_SHIFT : exp_diff[4:0];
  assign is_special = (exponentA == 8'hFF) || (exponentB == 8'hFF);

  logic [4:0]  step_k;
  logic [26:0] mant_shr;
  logic [26:0] lost_mask;
  logic        lost;

  assign step_k    = (remaining < STEP) ? remaining : STEP;
  assign mant_shr  = mantS >> step_k;
  assign lost_mask = ~(27'h7FF_FFFF << step_k);
  assign lost      = |(mantS & lost_mask);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (is_special || shift_init == 5'd0) ? DONE : SHIFT;
      SHIFT: if (remaining == step_k) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signL       <= 1'b0;
      signS       <= 1'b0;
      exponentOut <= 8'd0;
      mantL       <= 24'd0;
      mantS       <= 27'd0;
      swapped     <= 1'b0;
      special     <= 1'b0;
      remaining   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            signL       <= a_larger ? signA : signB;
            signS       <= a_larger ? signB : signA;
            exponentOut <= a_larger ? eff_a : eff_b;
            mantL       <= a_larger ? {hid_a, mantissaA} : {hid_b, mantissaB};
            mantS       <= a_larger ? {hid_b, mantissaB, 3'b000} : {hid_a, mantissaA, 3'b000};
            swapped     <= ~a_larger;
            special     <= is_special;
            remaining   <= is_special ? 5'd0 : shift_init;
          end
        end
        SHIFT: begin
          // Everything pushed past bit 0 folds into sticky.
          mantS     <= {mant_shr[26:1], mant_shr[0] | lost};
          remaining <= remaining - step_k;
        end
        default: ;
      endcase
    end
  end

endmodule
